// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and
// fetch/stall performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          SCNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [1:0]        Pcsrc,
    input  logic              stall,
    input  logic [31:0]       Bpc,
    input  logic [31:0]       Inst,
    output logic [31:0]       Iaddr,
    output logic [31:0]       Pc,
    output logic [31:0]       D_Inst,
    output logic [31:0]       D_Pc4,
    output logic              D_Valid,
    output logic [31:0]       Fcnt,
    output logic [SCNT_W-1:0] Scnt
);

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       d_inst_q, d_inst_d;
    logic [31:0]       d_pc4_q, d_pc4_d;
    logic              d_valid_q, d_valid_d;
    logic [31:0]       fcnt_q, fcnt_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;

    logic [31:0] pc4;
    logic [31:0] jpc;
    logic [31:0] bpc_aligned;
    logic        redirect;

    assign pc4         = pc_q + 32'd4;
    // J is resolved in ID, so its target comes from the IF/ID register.
    assign jpc         = {d_pc4_q[31:28], d_inst_q[25:0], 2'b00};
    assign bpc_aligned = Bpc & ~32'd3;
    assign redirect    = Pcsrc[1];

    always_comb begin
        pc_d      = pc_q;
        d_inst_d  = d_inst_q;
        d_pc4_d   = d_pc4_q;
        d_valid_d = d_valid_q;
        fcnt_d    = fcnt_q;
        scnt_d    = scnt_q;
        if (redirect) begin
            pc_d      = Pcsrc[0] ? jpc : bpc_aligned;
            d_inst_d  = 32'h0000_0000;
            d_pc4_d   = 32'h0000_0000;
            d_valid_d = 1'b0;
        end else if (stall) begin
            if (scnt_q != {SCNT_W{1'b1}}) begin
                scnt_d = scnt_q + 1'b1;
            end
        end else begin
            pc_d      = pc4;
            d_inst_d  = Inst;
            d_pc4_d   = pc4;
            d_valid_d = 1'b1;
            fcnt_d    = fcnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q      <= RESET_PC;
            d_inst_q  <= 32'h0000_0000;
            d_pc4_q   <= 32'h0000_0000;
            d_valid_q <= 1'b0;
            fcnt_q    <= 32'h0000_0000;
            scnt_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            d_inst_q  <= d_inst_d;
            d_pc4_q   <= d_pc4_d;
            d_valid_q <= d_valid_d;
            fcnt_q    <= fcnt_d;
            scnt_q    <= scnt_d;
        end
    end

    assign Iaddr   = pc_q;
    assign Pc      = pc_q;
    assign D_Inst  = d_inst_q;
    assign D_Pc4   = d_pc4_q;
    assign D_Valid = d_valid_q;
    assign Fcnt    = fcnt_q;
    assign Scnt    = scnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic against a
// behavioural fetch model; a second instance covers PC wrap and small Scnt.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pcsrc = 2'b00;
    logic        stall = 1'b0;
    logic [31:0] bpc = 32'h0;
    logic [31:0] inst;
    logic        rnd_mode = 1'b0;
    logic [31:0] iaddr, pc, d_inst, d_pc4, fcnt;
    logic        d_valid;
    logic [15:0] scnt;

    logic        rst2 = 1'b1;
    logic        stall2 = 1'b0;
    logic [1:0]  pcsrc2 = 2'b00;
    logic [31:0] bpc2 = 32'h0;
    logic [31:0] inst2;
    logic [31:0] iaddr2, pc2, d_inst2, d_pc42, fcnt2;
    logic        d_valid2;
    logic [1:0]  scnt2;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc, m_dinst, m_dpc4, m_fcnt;
    logic        m_valid;
    logic [15:0] m_scnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a, input logic rm);
        if (rm) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        if (a == 32'h4000_0004) return 32'h0800_0040;
        return a | 32'hA000_0000;
    endfunction

    assign inst  = mem_f(iaddr, rnd_mode);
    assign inst2 = iaddr2 | 32'hA000_0000;

    if_stage u_dut (
        .Clk(clk), .Rst(rst), .Pcsrc(pcsrc), .stall(stall), .Bpc(bpc), .Inst(inst),
        .Iaddr(iaddr), .Pc(pc), .D_Inst(d_inst), .D_Pc4(d_pc4), .D_Valid(d_valid),
        .Fcnt(fcnt), .Scnt(scnt)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .SCNT_W(2)) u_wrap (
        .Clk(clk), .Rst(rst2), .Pcsrc(pcsrc2), .stall(stall2), .Bpc(bpc2), .Inst(inst2),
        .Iaddr(iaddr2), .Pc(pc2), .D_Inst(d_inst2), .D_Pc4(d_pc42), .D_Valid(d_valid2),
        .Fcnt(fcnt2), .Scnt(scnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".Iaddr"},   iaddr,           m_pc);
        chk({tag, ".Pc"},      pc,              m_pc);
        chk({tag, ".D_Inst"},  d_inst,          m_dinst);
        chk({tag, ".D_Pc4"},   d_pc4,           m_dpc4);
        chk({tag, ".D_Valid"}, {31'd0, d_valid}, {31'd0, m_valid});
        chk({tag, ".Fcnt"},    fcnt,            m_fcnt);
        chk({tag, ".Scnt"},    {16'd0, scnt},   {16'd0, m_scnt});
    endtask

    // One clock: drive inputs at negedge, advance model at posedge, check #1 later.
    task automatic step(input string tag, input logic r, input logic [1:0] ps,
                        input logic st, input logic [31:0] b);
        @(negedge clk);
        rst = r; pcsrc = ps; stall = st; bpc = b;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_dinst = 32'h0; m_dpc4 = 32'h0; m_valid = 1'b0;
            m_fcnt = 32'h0; m_scnt = 16'h0;
        end else if (ps[1]) begin
            m_pc = ps[0] ? {m_dpc4[31:28], m_dinst[25:0], 2'b00} : {b[31:2], 2'b00};
            m_dinst = 32'h0; m_dpc4 = 32'h0; m_valid = 1'b0;
        end else if (st) begin
            if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
        end else begin
            m_dinst = mem_f(m_pc, rnd_mode);
            m_pc    = m_pc + 32'd4;
            m_dpc4  = m_pc;
            m_valid = 1'b1;
            m_fcnt  = m_fcnt + 32'd1;
        end
        #1;
        chk_all(tag);
    endtask

    task automatic step2(input logic r, input logic st);
        @(negedge clk);
        rst2 = r; stall2 = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_pc = 32'h0; m_dinst = 32'h0; m_dpc4 = 32'h0; m_valid = 1'b0;
        m_fcnt = 32'h0; m_scnt = 16'h0;

        // reset and sequential run
        step("rst0", 1'b1, 2'b00, 1'b0, 32'h0);
        step("rst1", 1'b1, 2'b00, 1'b0, 32'h0);
        repeat (3) step("seq", 1'b0, 2'b00, 1'b0, 32'h0);
        chk("seq3.Pc", pc, 32'h0000_000C);
        chk("seq3.D_Inst", d_inst, 32'hA000_0008);
        chk("seq3.D_Pc4", d_pc4, 32'h0000_000C);
        chk("seq3.Fcnt", fcnt, 32'd3);

        // stall hold at 0x10
        step("adv", 1'b0, 2'b00, 1'b0, 32'h0);
        chk("pre_stall.Pc", pc, 32'h10);
        step("stall_a", 1'b0, 2'b00, 1'b1, 32'h0);
        step("stall_b", 1'b0, 2'b00, 1'b1, 32'h0);
        chk("stall.Pc", pc, 32'h10);
        chk("stall.Scnt", {16'd0, scnt}, 32'd2);
        chk("stall.Fcnt", fcnt, 32'd4);
        step("resume", 1'b0, 2'b00, 1'b0, 32'h0);
        chk("resume.Pc", pc, 32'h14);

        // taken branch from 0x20
        repeat (3) step("adv", 1'b0, 2'b00, 1'b0, 32'h0);
        chk("pre_br.Pc", pc, 32'h20);
        step("branch", 1'b0, 2'b10, 1'b0, 32'h0000_0103);
        chk("branch.Pc", pc, 32'h100);
        chk("branch.D_Valid", {31'd0, d_valid}, 32'd0);
        step("br_next", 1'b0, 2'b00, 1'b0, 32'h0);
        chk("br_next.D_Pc4", d_pc4, 32'h104);

        // jump: land at 0x4000_0004 whose word is 0x0800_0040
        step("br_j", 1'b0, 2'b10, 1'b0, 32'h4000_0004);
        step("fetch_j", 1'b0, 2'b00, 1'b0, 32'h0);
        chk("fetch_j.D_Inst", d_inst, 32'h0800_0040);
        chk("fetch_j.D_Pc4", d_pc4, 32'h4000_0008);
        step("jump", 1'b0, 2'b11, 1'b0, 32'h0);
        chk("jump.Pc", pc, 32'h4000_0100);
        chk("jump.D_Inst", d_inst, 32'h0);

        // redirect beats stall; reset beats stall
        step("br_stall", 1'b0, 2'b10, 1'b1, 32'h0000_0200);
        chk("br_stall.Pc", pc, 32'h200);
        chk("br_stall.Scnt", {16'd0, scnt}, 32'd2);
        step("rst_stall", 1'b1, 2'b00, 1'b1, 32'h0);
        chk("rst_stall.Scnt", {16'd0, scnt}, 32'd0);
        step("rst_rel", 1'b0, 2'b00, 1'b0, 32'h0);
        chk("rst_rel.Pc", pc, 32'h4);

        // random traffic against the model
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic        r, st;
            logic [1:0]  ps;
            r  = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 3) == 0);
            ps = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            step("rnd", r, ps, st, $urandom);
        end

        // wrap instance: RESET_PC = 0xFFFF_FFFC, SCNT_W = 2
        step2(1'b1, 1'b0);
        chk("wrap.rst.Pc", pc2, 32'hFFFF_FFFC);
        chk("wrap.rst.Scnt", {30'd0, scnt2}, 32'd0);
        step2(1'b0, 1'b0);
        chk("wrap.Pc", pc2, 32'h0);
        chk("wrap.D_Pc4", d_pc42, 32'h0);
        chk("wrap.D_Inst", d_inst2, 32'hFFFF_FFFC);
        chk("wrap.D_Valid", {31'd0, d_valid2}, 32'd1);
        repeat (2) step2(1'b0, 1'b1);
        chk("sat2.Scnt", {30'd0, scnt2}, 32'd2);
        repeat (3) step2(1'b0, 1'b1);
        chk("sat5.Scnt", {30'd0, scnt2}, 32'd3);
        chk("sat5.Pc", pc2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
